// File: rtl/bp_pkg.sv
// Types shared between the trace driver and the branch predictor it exercises.
package bp_pkg;

    // 2-bit saturating predictor state; bit 1 set means "predict taken".
    typedef logic [1:0] state_t;

endpackage

// File: rtl/bp_trace_driver_if.sv
// Control and predictor-facing signals of the branch-predictor trace driver.
interface bp_trace_driver_if #(
    parameter int PAT_W = 32,
    parameter int CNT_W = 16
);
    localparam int LEN_W = $clog2(PAT_W) + 1;

    logic                start;
    logic [PAT_W-1:0]    pattern;
    logic [LEN_W-1:0]    length;
    logic [7:0]          passes;
    logic                bp_reset_n;
    logic                taken;
    bp_pkg::state_t      prediction;
    logic                busy;
    logic                done;
    logic [CNT_W-1:0]    hit_count;
    logic [CNT_W-1:0]    miss_count;

    modport master (
        output start, pattern, length, passes, prediction,
        input  bp_reset_n, taken, busy, done, hit_count, miss_count
    );

    modport slave (
        input  start, pattern, length, passes, prediction,
        output bp_reset_n, taken, busy, done, hit_count, miss_count
    );

endinterface

// File: rtl/bp_trace_driver.sv
// Replays a captured branch-outcome pattern into a predictor, resetting it first,
// and scores each prediction against the outcome it is about to be trained on.
module bp_trace_driver #(
    parameter int PAT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    bp_trace_driver_if.slave bus
);

    localparam int                LEN_W   = $clog2(PAT_W) + 1;
    localparam int                IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_DONE
    } fsm_t;

    fsm_t             state_q,    state_d;
    logic [PAT_W-1:0] pattern_q,  pattern_d;
    logic [LEN_W-1:0] length_q,   length_d;
    logic [7:0]       passes_q,   passes_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic [7:0]       pass_q,     pass_d;
    logic             rst_cnt_q,  rst_cnt_d;
    logic [CNT_W-1:0] hit_q,      hit_d;
    logic [CNT_W-1:0] miss_q,     miss_d;
    logic             bp_rst_n_q, bp_rst_n_d;

    logic             taken_w;
    logic             pred_taken;
    logic             last_idx;
    logic             cfg_bad;

    always_comb begin
        pred_taken = (bus.prediction >= 2'b10);
        taken_w    = 1'b0;
        if (state_q == S_RUN) begin
            taken_w = pattern_q[idx_q];
        end
        last_idx = (LEN_W'(idx_q) == (length_q - LEN_W'(1)));
        cfg_bad  = (bus.length == '0) || (bus.length > MAX_LEN) || (bus.passes == 8'd0);
    end

    always_comb begin
        state_d    = state_q;
        pattern_d  = pattern_q;
        length_d   = length_q;
        passes_d   = passes_q;
        idx_d      = idx_q;
        pass_d     = pass_q;
        rst_cnt_d  = rst_cnt_q;
        hit_d      = hit_q;
        miss_d     = miss_q;
        bp_rst_n_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pattern_d = bus.pattern;
                    length_d  = bus.length;
                    passes_d  = bus.passes;
                    hit_d     = '0;
                    miss_d    = '0;
                    rst_cnt_d = 1'b0;
                    // An empty trace still completes, but never touches the predictor.
                    state_d   = cfg_bad ? S_DONE : S_RST;
                end
            end

            S_RST: begin
                rst_cnt_d = 1'b1;
                if (rst_cnt_q) begin
                    idx_d   = '0;
                    pass_d  = 8'd1;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                // The predictor state seen here predates this cycle's training outcome.
                if (pred_taken == taken_w) begin
                    hit_d = (hit_q == CNT_MAX) ? hit_q : hit_q + CNT_W'(1);
                end else begin
                    miss_d = (miss_q == CNT_MAX) ? miss_q : miss_q + CNT_W'(1);
                end
                if (last_idx) begin
                    if (pass_q == passes_q) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d  = '0;
                        pass_d = pass_q + 8'd1;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pattern_q  <= '0;
            length_q   <= '0;
            passes_q   <= '0;
            idx_q      <= '0;
            pass_q     <= '0;
            rst_cnt_q  <= 1'b0;
            hit_q      <= '0;
            miss_q     <= '0;
            bp_rst_n_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            length_q   <= length_d;
            passes_q   <= passes_d;
            idx_q      <= idx_d;
            pass_q     <= pass_d;
            rst_cnt_q  <= rst_cnt_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            bp_rst_n_q <= bp_rst_n_d;
        end
    end

    // The predictor is held in reset both by our own reset and by the RST phase.
    assign bus.bp_reset_n = bp_rst_n_q && (state_q != S_RST);
    assign bus.taken      = taken_w;
    assign bus.busy       = (state_q == S_RST) || (state_q == S_RUN);
    assign bus.done       = (state_q == S_DONE);
    assign bus.hit_count  = hit_q;
    assign bus.miss_count = miss_q;

endmodule

// File: tb/tb_bp_trace_driver.sv
// Directed scoreboard bench for bp_trace_driver: expected taken streams and
// trace results are queued at start and consumed by an independent monitor.
module tb_bp_trace_driver;

    logic clk = 1'b0;
    logic reset;
    logic reset_b;

    always #5 clk = ~clk;

    bp_trace_driver_if #(.PAT_W(32), .CNT_W(16)) ifa ();
    bp_trace_driver_if #(.PAT_W(8),  .CNT_W(4))  ifb ();

    bp_trace_driver #(.PAT_W(32), .CNT_W(16)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    bp_trace_driver #(.PAT_W(8), .CNT_W(4)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (ifb.slave)
    );

    // The second instance sees a perfect predictor.
    assign ifb.prediction = {ifb.taken, 1'b0};

    typedef struct {
        int hit;
        int miss;
        int done_cyc;
        int rst_cycles;
    } exp_t;

    exp_t exp_res[$];
    bit   exp_taken[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   rst_low_cnt = 0;
    bit   busy_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check_output(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void flag_fail(string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got event want none (cycle %0d)", name, cyc);
    endfunction

    // Monitor: consumes the expected taken stream in RUN and the result record at done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                rst_low_cnt = 0;
            end else if (ifa.busy && !ifa.bp_reset_n) begin
                rst_low_cnt++;
            end
            if (ifa.busy) busy_seen = 1'b1;
            if (ifa.busy && ifa.bp_reset_n) begin
                if (exp_taken.size() == 0) flag_fail("taken_extra");
                else check_output("taken", 32'(ifa.taken), 32'(exp_taken.pop_front()));
            end else begin
                check_output("taken_idle", 32'(ifa.taken), 32'd0);
            end
            if (ifa.done) begin
                if (exp_res.size() == 0) begin
                    flag_fail("unexpected_done");
                end else begin
                    e = exp_res.pop_front();
                    check_output("hit_count", 32'(ifa.hit_count), e.hit);
                    check_output("miss_count", 32'(ifa.miss_count), e.miss);
                    check_output("done_cycle", cyc, e.done_cyc);
                    check_output("rst_cycles", rst_low_cnt, e.rst_cycles);
                    check_output("busy_in_done", 32'(ifa.busy), 32'd0);
                end
                rst_low_cnt = 0;
            end
        end
    end

    task automatic push_taken(input logic [31:0] pat, input int len, input int pas, input int limit);
        int n = 0;
        for (int p = 0; p < pas; p++) begin
            for (int i = 0; i < len; i++) begin
                if (n < limit) exp_taken.push_back(pat[i]);
                n++;
            end
        end
    endtask

    task automatic drive_start(input logic [31:0] pat, input logic [5:0] len,
                               input logic [7:0] pas, input logic [1:0] pred);
        ifa.pattern    = pat;
        ifa.length     = len;
        ifa.passes     = pas;
        ifa.prediction = pred;
        ifa.start      = 1'b1;
    endtask

    task automatic apply_stimulus(input logic [31:0] pat, input logic [5:0] len,
                                  input logic [7:0] pas, input logic [1:0] pred,
                                  input int hit, input int miss, input int lat,
                                  input int rst_cycles);
        exp_t e;
        if (rst_cycles != 0) push_taken(pat, int'(len), int'(pas), 1000);
        @(posedge clk); #1;
        drive_start(pat, len, pas, pred);
        e.hit        = hit;
        e.miss       = miss;
        e.done_cyc   = cyc + lat;
        e.rst_cycles = rst_cycles;
        exp_res.push_back(e);
        @(posedge clk); #1;
        ifa.start = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int k;
        for (k = 0; k < limit; k++) begin
            if (exp_res.size() == 0 && exp_taken.size() == 0 && !ifa.busy && !ifa.done) break;
            @(posedge clk); #1;
        end
        if (k == limit) begin
            flag_fail("drain_timeout");
            exp_res.delete();
            exp_taken.delete();
        end
    endtask

    initial begin
        bit found;
        reset   = 1'b1;
        reset_b = 1'b1;
        ifa.start = 1'b0; ifa.pattern = '0; ifa.length = '0; ifa.passes = '0; ifa.prediction = 2'b00;
        ifb.start = 1'b0; ifb.pattern = '0; ifb.length = '0; ifb.passes = '0;

        repeat (3) @(posedge clk);
        #1;
        check_output("rst_busy", 32'(ifa.busy), 32'd0);
        check_output("rst_done", 32'(ifa.done), 32'd0);
        check_output("rst_hit", 32'(ifa.hit_count), 32'd0);
        check_output("rst_miss", 32'(ifa.miss_count), 32'd0);
        check_output("rst_bp_reset_n", 32'(ifa.bp_reset_n), 32'd0);
        reset   = 1'b0;
        reset_b = 1'b0;
        @(posedge clk); #1;
        check_output("bp_reset_n_release", 32'(ifa.bp_reset_n), 32'd1);
        check_output("bp_reset_n_release_b", 32'(ifb.bp_reset_n), 32'd1);

        $display("[TB] all-taken pattern, two passes");
        apply_stimulus(32'hF, 6'd4, 8'd2, 2'b11, 8, 0, 11, 2);
        wait_drain(60);
        check_output("hold_hit", 32'(ifa.hit_count), 32'd8);
        check_output("hold_miss", 32'(ifa.miss_count), 32'd0);

        $display("[TB] alternating pattern, not-taken predictor");
        apply_stimulus(32'b0101, 6'd4, 8'd1, 2'b00, 2, 2, 7, 2);
        wait_drain(60);

        $display("[TB] degenerate configurations");
        busy_seen = 1'b0;
        apply_stimulus(32'hF, 6'd0, 8'd3, 2'b11, 0, 0, 1, 0);
        wait_drain(20);
        apply_stimulus(32'hF, 6'd4, 8'd0, 2'b11, 0, 0, 1, 0);
        wait_drain(20);
        apply_stimulus(32'hF, 6'd33, 8'd1, 2'b11, 0, 0, 1, 0);
        wait_drain(20);
        check_output("busy_never", 32'(busy_seen), 32'd0);

        $display("[TB] full-length pattern");
        apply_stimulus(32'h8000_0001, 6'd32, 8'd1, 2'b10, 2, 30, 35, 2);
        wait_drain(80);

        $display("[TB] start and pattern disturbed mid-run");
        apply_stimulus(32'b0110, 6'd4, 8'd2, 2'b10, 4, 4, 11, 2);
        repeat (3) @(posedge clk);
        #1;
        ifa.start   = 1'b1;
        ifa.pattern = 32'hFFFF_FFFF;
        ifa.length  = 6'd1;
        ifa.passes  = 8'd1;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        wait_drain(60);

        $display("[TB] reset in third run cycle");
        push_taken(32'hF, 4, 2, 3);
        @(posedge clk); #1;
        drive_start(32'hF, 6'd4, 8'd2, 2'b11);
        @(posedge clk); #1;
        ifa.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_output("abort_hit", 32'(ifa.hit_count), 32'd0);
        check_output("abort_miss", 32'(ifa.miss_count), 32'd0);
        check_output("abort_bp_reset_n", 32'(ifa.bp_reset_n), 32'd0);
        check_output("abort_busy", 32'(ifa.busy), 32'd0);
        check_output("abort_taken_used", exp_taken.size(), 32'd0);
        ifa.start = 1'b1;
        @(posedge clk); #1;
        check_output("start_with_reset", 32'(ifa.busy), 32'd0);
        ifa.start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check_output("abort_release_bp_n", 32'(ifa.bp_reset_n), 32'd1);
        check_output("abort_release_busy", 32'(ifa.busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        apply_stimulus(32'hF, 6'd4, 8'd2, 2'b11, 8, 0, 11, 2);
        wait_drain(60);

        $display("[TB] saturating 4-bit counters");
        @(posedge clk); #1;
        ifb.pattern = 8'hA5;
        ifb.length  = 4'd8;
        ifb.passes  = 8'd4;
        ifb.start   = 1'b1;
        @(posedge clk); #1;
        ifb.start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (ifb.done) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check_output("sat_done_seen", 32'(found), 32'd1);
        check_output("sat_hit", 32'(ifb.hit_count), 32'd15);
        check_output("sat_miss", 32'(ifb.miss_count), 32'd0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
